m_ram_ctrl: RTL and testbench
=============================

Name: m_ram_ctrl

Overview:
- Front-end controller sitting directly upstream of the 64x4 RAM (m_ram). It consumes debounced push-button levels (from m_chattering) and 4 data switches.
- It produces a stable address, write data, and a glitch-free, timed write-enable pulse: setup, then pulse, then hold.
- Supports address step up/down with wrap-around, and a bulk "clear" sequence that writes CLR_VAL to every location.
- adr also feeds the address display (m_seven_segment_2) and the RAM read port.

Parameters:
- AW, 6, address width; depth = 2**AW.
- DW, 4, data width.
- WE_W, 2, write-enable pulse width in clk cycles (>=1).
- CLR_VAL, 4'h0, value written to every location by the clear sequence.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn_up  input  1  debounced level; rising edge increments address.
- btn_dn  input  1  debounced level; rising edge decrements address.
- btn_wr  input  1  debounced level; rising edge starts a single write.
- btn_clr  input  1  debounced level; rising edge starts the clear sequence.
- sw_data  input  DW  data switches, sampled at write start.
- adr  output  AW  RAM address (registered).
- wdata  output  DW  RAM write data (registered).
- we  output  1  RAM write strobe (registered, glitch-free).
- busy  output  1  high while a write or clear is in progress.

Behaviour:
- Reset (async, rst_n=0): adr=0, wdata=0, we=0, busy=0, FSM=IDLE, pulse counter=0. Edge-detector history registers reset to 1, so a button already held at reset release does not fire.
- Edge detect: rise_x = btn_x & ~prev_x, with prev_x <= btn_x every cycle. Inputs are already synchronous (debounced upstream).
- FSM states: IDLE, SETUP, PULSE, HOLD, CLR_NEXT.
- IDLE priority, evaluated once per cycle: rise_clr > rise_wr > up/dn.
  - rise_clr: adr<=0, wdata<=CLR_VAL, busy<=1, clr_mode<=1, ->SETUP.
  - rise_wr: wdata<=sw_data, busy<=1, clr_mode<=0, ->SETUP.
  - rise_up & ~rise_dn: adr<=adr+1, wrapping 63->0.
  - rise_dn & ~rise_up: adr<=adr-1, wrapping 0->63.
  - rise_up & rise_dn together: adr unchanged.
- SETUP: 1 cycle, we=0 (address/data settle) ->PULSE; load cnt=WE_W-1.
- PULSE: we=1; decrement cnt each cycle; when cnt==0 ->HOLD. we is high for exactly WE_W cycles.
- HOLD: 1 cycle, we=0; adr/wdata still stable.
  - If ~clr_mode: busy<=0, ->IDLE.
  - If clr_mode: ->CLR_NEXT.
- CLR_NEXT:
  - If adr==2**AW-1: adr<=0, busy<=0, clr_mode<=0, ->IDLE.
  - Otherwise: adr<=adr+1, ->SETUP.
- adr and wdata never change while we=1 or in the SETUP/HOLD cycles.
- Single write latency: rise_wr seen in cycle k -> SETUP at k+1 -> we=1 in cycles k+2 .. k+1+WE_W -> HOLD -> IDLE with busy=0 at cycle k+3+WE_W.
- Clear duration: 2**AW*(WE_W+3) cycles; ends with adr=0.
- While busy, all button edges are discarded, not queued. prev_x keeps tracking, so a button held through busy does not fire afterwards.
- sw_data changes after the write starts have no effect on the write in progress.
- Reset mid-operation: we drops asynchronously. The RAM location being written is undefined, and the bench must not check it.

Decomposition:
- Shared include ram_ctrl_defs.vh holds the state encodings (IDLE=3'd0, SETUP=3'd1, PULSE=3'd2, HOLD=3'd3, CLR_NEXT=3'd4) and the AW/DW defaults shared with m_ram and the display.
- One sub-module, m_rise_edge (clk, rst_n, in, rise), instantiated four times. Its prev register resets to 1.

Test Plan:
- Reset release with btn_up held high -> no increment, adr=0. Then release btn_up and press it 3 times -> adr=3. Press btn_dn 4 times -> adr=63 (wrap).
- adr=5, sw_data=4'hA, pulse btn_wr (WE_W=2) -> we high exactly cycles k+2,k+3; adr=5 and wdata=A stable from k+1 to k+4; busy falls at k+5; RAM[5]=A.
- During that write, change sw_data to 4'h3 and pulse btn_up -> RAM[5] still A, adr stays 5 after the write.
- btn_up and btn_dn rise in the same cycle at adr=10 -> adr=10. btn_clr and btn_wr rise together -> the clear sequence runs, not the single write.
- Fill RAM with non-zero values, pulse btn_clr -> 64 we pulses, busy high for 64*5=320 cycles, all RAM locations = 0, final adr=0.
- Assert rst_n=0 during PULSE of a clear at adr=20 -> we, busy and adr go to 0 immediately (no clock needed); FSM in IDLE after release; a later single write works normally.

Source files
------------

// File: rtl/m_ram_ctrl_pkg.sv
// rtl/m_ram_ctrl_pkg.sv - shared widths, defaults and FSM encoding for the RAM front-end
package m_ram_ctrl_pkg;

  localparam int unsigned AW_DEF   = 6;
  localparam int unsigned DW_DEF   = 4;
  localparam int unsigned WE_W_DEF = 2;

  // Encoding is shared with m_ram and the display block, so keep values fixed.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_PULSE    = 3'd2,
    ST_HOLD     = 3'd3,
    ST_CLR_NEXT = 3'd4
  } state_t;

  function automatic bit is_busy_state(state_t s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/m_ram_ctrl_if.sv
// rtl/m_ram_ctrl_if.sv - button/switch inputs and RAM-side outputs of the controller
interface m_ram_ctrl_if
  import m_ram_ctrl_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) ();

  logic          btn_up;
  logic          btn_dn;
  logic          btn_wr;
  logic          btn_clr;
  logic [DW-1:0] sw_data;
  logic [AW-1:0] adr;
  logic [DW-1:0] wdata;
  logic          we;
  logic          busy;

  modport master (
    output btn_up, btn_dn, btn_wr, btn_clr, sw_data,
    input  adr, wdata, we, busy
  );

  modport slave (
    input  btn_up, btn_dn, btn_wr, btn_clr, sw_data,
    output adr, wdata, we, busy
  );

endinterface

// File: rtl/m_ram_ctrl_rise_edge.sv
// rtl/m_ram_ctrl_rise_edge.sv - rising-edge detector for an already-synchronous level
module m_rise_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic rise
);

  logic prev_q;

  // History resets high so a button held through reset release does not fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= in;
    end
  end

  assign rise = in & ~prev_q;

endmodule

// File: rtl/m_ram_ctrl.sv
// rtl/m_ram_ctrl.sv - RAM front-end: address stepping, timed single write, bulk clear
module m_ram_ctrl
  import m_ram_ctrl_pkg::*;
#(
  parameter int unsigned   AW      = AW_DEF,
  parameter int unsigned   DW      = DW_DEF,
  parameter int unsigned   WE_W    = WE_W_DEF,
  parameter logic [DW-1:0] CLR_VAL = '0
) (
  input logic         clk,
  input logic         rst_n,
  m_ram_ctrl_if.slave bus
);

  localparam int unsigned   CW       = (WE_W > 1) ? $clog2(WE_W) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WE_W - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          clr_mode_q, clr_mode_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic rise_up, rise_dn, rise_wr, rise_clr;

  m_rise_edge u_rise_up  (.clk(clk), .rst_n(rst_n), .in(bus.btn_up),  .rise(rise_up));
  m_rise_edge u_rise_dn  (.clk(clk), .rst_n(rst_n), .in(bus.btn_dn),  .rise(rise_dn));
  m_rise_edge u_rise_wr  (.clk(clk), .rst_n(rst_n), .in(bus.btn_wr),  .rise(rise_wr));
  m_rise_edge u_rise_clr (.clk(clk), .rst_n(rst_n), .in(bus.btn_clr), .rise(rise_clr));

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    clr_mode_d = clr_mode_q;
    cnt_d      = cnt_q;
    we_d       = 1'b0;

    // Button edges outside IDLE are dropped; the detectors keep tracking regardless.
    unique case (state_q)
      ST_IDLE: begin
        if (rise_clr) begin
          adr_d      = '0;
          wdata_d    = CLR_VAL;
          busy_d     = 1'b1;
          clr_mode_d = 1'b1;
          state_d    = ST_SETUP;
        end else if (rise_wr) begin
          wdata_d    = bus.sw_data;
          busy_d     = 1'b1;
          clr_mode_d = 1'b0;
          state_d    = ST_SETUP;
        end else if (rise_up && !rise_dn) begin
          adr_d = adr_q + 1'b1;
        end else if (rise_dn && !rise_up) begin
          adr_d = adr_q - 1'b1;
        end
      end

      ST_SETUP: begin
        cnt_d   = CNT_LOAD;
        we_d    = 1'b1;
        state_d = ST_PULSE;
      end

      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
          we_d  = 1'b1;
        end
      end

      ST_HOLD: begin
        if (clr_mode_q) begin
          state_d = ST_CLR_NEXT;
        end else begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      ST_CLR_NEXT: begin
        if (adr_q == {AW{1'b1}}) begin
          adr_d      = '0;
          busy_d     = 1'b0;
          clr_mode_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          adr_d   = adr_q + 1'b1;
          state_d = ST_SETUP;
        end
      end

      default: begin
        busy_d     = 1'b0;
        clr_mode_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // we is a flop output, so an async reset drops the strobe without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      adr_q      <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      clr_mode_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      clr_mode_q <= clr_mode_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.adr   = adr_q;
  assign bus.wdata = wdata_q;
  assign bus.we    = we_q;
  assign bus.busy  = busy_q;

  a_we_only_in_pulse: assert property (
    @(posedge clk) disable iff (!rst_n) we_q == (state_q == ST_PULSE));

  a_busy_matches_state: assert property (
    @(posedge clk) disable iff (!rst_n) busy_q == is_busy_state(state_q));

  a_bus_stable_in_write: assert property (
    @(posedge clk) disable iff (!rst_n)
      (state_q == ST_PULSE || state_q == ST_HOLD) |-> ($stable(adr_q) && $stable(wdata_q)));

endmodule

// File: tb/tb_m_ram_ctrl.sv
// tb/tb_m_ram_ctrl.sv - randomized self-checking bench for m_ram_ctrl with a RAM and address model
module tb_m_ram_ctrl;

  localparam int WE_W  = 2;
  localparam int DEPTH = 64;
  localparam logic [3:0] CLR_VAL = 4'h0;

  logic clk = 1'b0;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  int         exp_adr;
  logic [3:0] exp_mem   [DEPTH];
  bit         exp_valid [DEPTH];
  logic [3:0] ram       [DEPTH];

  always #5 clk = ~clk;

  m_ram_ctrl_if #(.AW(6), .DW(4)) bus ();

  m_ram_ctrl #(
    .AW(6), .DW(4), .WE_W(WE_W), .CLR_VAL(CLR_VAL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always @(posedge clk) begin
    if (bus.we === 1'b1) ram[bus.adr] <= bus.wdata;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int adr_after(input int a, input bit up, input bit dn);
    if (up && !dn) return (a + 1) % DEPTH;
    if (dn && !up) return (a + DEPTH - 1) % DEPTH;
    return a;
  endfunction

  task automatic press(input bit up, input bit dn);
    bus.btn_up = up;
    bus.btn_dn = dn;
    step(1);
    bus.btn_up = 1'b0;
    bus.btn_dn = 1'b0;
    step(1);
    exp_adr = adr_after(exp_adr, up, dn);
  endtask

  task automatic goto_adr(input int target);
    int diff;
    diff = (target - exp_adr + DEPTH) % DEPTH;
    if (diff <= DEPTH / 2) repeat (diff) press(1'b1, 1'b0);
    else repeat (DEPTH - diff) press(1'b0, 1'b1);
  endtask

  // Single write: busy spans SETUP + WE_W pulse cycles + HOLD, counted from the cycle after the edge.
  task automatic do_write(input logic [3:0] data, input bit disturb, input bit hold_dn,
                          output int busy_n, output int we_n, output bit timing_ok);
    logic [5:0] a0;
    int c;
    a0        = 6'(exp_adr);
    busy_n    = 0;
    we_n      = 0;
    timing_ok = 1'b1;
    bus.sw_data = data;
    bus.btn_wr  = 1'b1;
    step(1);
    bus.btn_wr = 1'b0;
    if (hold_dn) bus.btn_dn = 1'b1;
    c = 1;
    while (bus.busy === 1'b1 && c < 50) begin
      busy_n++;
      if (bus.we === 1'b1) we_n++;
      if (bus.we !== ((c >= 2 && c <= 1 + WE_W) ? 1'b1 : 1'b0)) timing_ok = 1'b0;
      if (bus.adr !== a0 || bus.wdata !== data) timing_ok = 1'b0;
      if (disturb) begin
        bus.sw_data = ~data;
        bus.btn_up  = (c == 2);
      end
      step(1);
      c++;
    end
    bus.btn_up = 1'b0;
    step(2);
    bus.btn_dn = 1'b0;
    step(2);
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.btn_up  = 1'b1;
    bus.btn_dn  = 1'b0;
    bus.btn_wr  = 1'b0;
    bus.btn_clr = 1'b0;
    bus.sw_data = 4'h0;
    step(3);
    checks++;
    if (bus.adr !== 6'd0 || bus.we !== 1'b0 || bus.busy !== 1'b0 || bus.wdata !== 4'd0) begin
      failures++;
      $display("FAIL reset_outputs: adr=%0d we=%b busy=%b wdata=%0h, required all zero",
               bus.adr, bus.we, bus.busy, bus.wdata);
    end
    rst_n = 1'b1;
    step(4);
    checks++;
    if (bus.adr !== 6'd0) begin
      failures++;
      $display("FAIL held_up_at_release: adr=%0d required 0", bus.adr);
    end
    bus.btn_up = 1'b0;
    step(1);
    exp_adr = 0;
    repeat (3) press(1'b1, 1'b0);
    checks++;
    if (bus.adr !== 6'(exp_adr)) begin
      failures++;
      $display("FAIL up_three: adr=%0d required %0d", bus.adr, exp_adr);
    end
    repeat (4) press(1'b0, 1'b1);
    checks++;
    if (bus.adr !== 6'(exp_adr)) begin
      failures++;
      $display("FAIL down_wrap: adr=%0d required %0d", bus.adr, exp_adr);
    end
  endtask

  task automatic test_random_steps();
    int op;
    for (int i = 0; i < 30; i++) begin
      op = int'($urandom_range(0, 3));
      if (op == 3) step(int'($urandom_range(1, 3)));
      else press(op == 0 || op == 2, op == 1 || op == 2);
      checks++;
      if (bus.adr !== 6'(exp_adr)) begin
        failures++;
        $display("FAIL random_step[%0d] op=%0d: adr=%0d required %0d", i, op, bus.adr, exp_adr);
      end
    end
  endtask

  task automatic test_single_write();
    int busy_n, we_n, target;
    bit ok;
    logic [3:0] data;
    for (int i = 0; i < 7; i++) begin
      target = (i == 0) ? 5 : int'($urandom_range(0, DEPTH - 1));
      data   = (i == 0) ? 4'hA : 4'($urandom);
      goto_adr(target);
      do_write(data, 1'b0, 1'b0, busy_n, we_n, ok);
      exp_mem[target]   = data;
      exp_valid[target] = 1'b1;
      checks++;
      if (busy_n != WE_W + 2 || we_n != WE_W || !ok) begin
        failures++;
        $display("FAIL write_timing[%0d]: busy_cycles=%0d we_cycles=%0d shape_ok=%0d, required %0d %0d 1",
                 i, busy_n, we_n, ok, WE_W + 2, WE_W);
      end
      checks++;
      if (ram[target] !== data || bus.adr !== 6'(target)) begin
        failures++;
        $display("FAIL write_data[%0d]: ram[%0d]=%0h adr=%0d, required %0h at adr %0d",
                 i, target, ram[target], bus.adr, data, target);
      end
    end
  endtask

  task automatic test_write_disturb();
    int busy_n, we_n;
    bit ok;
    goto_adr(5);
    do_write(4'hA, 1'b1, 1'b1, busy_n, we_n, ok);
    exp_mem[5]   = 4'hA;
    exp_valid[5] = 1'b1;
    checks++;
    if (busy_n != WE_W + 2 || we_n != WE_W || !ok) begin
      failures++;
      $display("FAIL disturb_timing: busy_cycles=%0d we_cycles=%0d shape_ok=%0d, required %0d %0d 1",
               busy_n, we_n, ok, WE_W + 2, WE_W);
    end
    checks++;
    if (ram[5] !== 4'hA || bus.adr !== 6'd5) begin
      failures++;
      $display("FAIL disturb_result: ram[5]=%0h adr=%0d, required a at adr 5", ram[5], bus.adr);
    end
  endtask

  task automatic test_simultaneous();
    int busy_n, we_n, cycles, we_cyc, pulses, bad_adr, bad_mem;
    bit ok, prev_we;
    goto_adr(10);
    press(1'b1, 1'b1);
    checks++;
    if (bus.adr !== 6'd10) begin
      failures++;
      $display("FAIL up_dn_together: adr=%0d required 10", bus.adr);
    end
    for (int a = 0; a < DEPTH; a++) begin
      goto_adr(a);
      do_write(4'($urandom_range(1, 15)), 1'b0, 1'b0, busy_n, we_n, ok);
      exp_mem[a]   = bus.sw_data;
      exp_valid[a] = 1'b1;
    end
    bad_mem = 0;
    for (int a = 0; a < DEPTH; a++) if (ram[a] !== exp_mem[a] || ram[a] === CLR_VAL) bad_mem++;
    checks++;
    if (bad_mem != 0) begin
      failures++;
      $display("FAIL fill_ram: %0d locations wrong, required 0", bad_mem);
    end
    bus.sw_data = 4'hF;
    bus.btn_clr = 1'b1;
    bus.btn_wr  = 1'b1;
    step(1);
    bus.btn_clr = 1'b0;
    bus.btn_wr  = 1'b0;
    cycles = 0; we_cyc = 0; pulses = 0; bad_adr = 0; prev_we = 1'b0;
    while (bus.busy === 1'b1 && cycles < 400) begin
      if (bus.we === 1'b1) begin
        we_cyc++;
        if (!prev_we) begin
          if (bus.adr !== 6'(pulses) || bus.wdata !== CLR_VAL) bad_adr++;
          pulses++;
        end
      end
      prev_we = (bus.we === 1'b1);
      cycles++;
      step(1);
    end
    exp_adr = 0;
    for (int a = 0; a < DEPTH; a++) exp_mem[a] = CLR_VAL;
    checks++;
    if (cycles != DEPTH * (WE_W + 3)) begin
      failures++;
      $display("FAIL clear_busy_cycles: got %0d required %0d", cycles, DEPTH * (WE_W + 3));
    end
    checks++;
    if (pulses != DEPTH || we_cyc != DEPTH * WE_W || bad_adr != 0) begin
      failures++;
      $display("FAIL clear_pulses: pulses=%0d we_cycles=%0d misplaced=%0d, required %0d %0d 0",
               pulses, we_cyc, bad_adr, DEPTH, DEPTH * WE_W);
    end
    bad_mem = 0;
    for (int a = 0; a < DEPTH; a++) if (ram[a] !== exp_mem[a]) bad_mem++;
    checks++;
    if (bad_mem != 0 || bus.adr !== 6'd0) begin
      failures++;
      $display("FAIL clear_result: %0d locations not cleared, adr=%0d, required 0 and 0", bad_mem, bus.adr);
    end
  endtask

  task automatic test_reset_mid_clear();
    int waited, busy_n, we_n, target, bad_mem;
    bit ok;
    logic [3:0] data;
    bus.btn_clr = 1'b1;
    step(1);
    bus.btn_clr = 1'b0;
    waited = 0;
    while (!(bus.adr === 6'd20 && bus.we === 1'b1) && waited < 200) begin
      step(1);
      waited++;
    end
    checks++;
    if (waited >= 200) begin
      failures++;
      $display("FAIL reach_adr20_pulse: timed out after %0d cycles, adr=%0d", waited, bus.adr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.we !== 1'b0 || bus.busy !== 1'b0 || bus.adr !== 6'd0) begin
      failures++;
      $display("FAIL async_reset: we=%b busy=%b adr=%0d, required 0 0 0", bus.we, bus.busy, bus.adr);
    end
    exp_valid[20] = 1'b0;
    exp_adr = 0;
    step(2);
    rst_n = 1'b1;
    step(3);
    checks++;
    if (bus.we !== 1'b0 || bus.busy !== 1'b0 || bus.adr !== 6'd0) begin
      failures++;
      $display("FAIL after_release: we=%b busy=%b adr=%0d, required 0 0 0", bus.we, bus.busy, bus.adr);
    end
    target = int'($urandom_range(21, DEPTH - 1));
    data   = 4'($urandom_range(1, 15));
    goto_adr(target);
    do_write(data, 1'b0, 1'b0, busy_n, we_n, ok);
    exp_mem[target]   = data;
    exp_valid[target] = 1'b1;
    checks++;
    if (busy_n != WE_W + 2 || we_n != WE_W || !ok || ram[target] !== data) begin
      failures++;
      $display("FAIL write_after_reset: busy_cycles=%0d we_cycles=%0d shape_ok=%0d ram=%0h, required %0d %0d 1 %0h",
               busy_n, we_n, ok, ram[target], WE_W + 2, WE_W, data);
    end
    bad_mem = 0;
    for (int a = 0; a < DEPTH; a++) if (exp_valid[a] && ram[a] !== exp_mem[a]) bad_mem++;
    checks++;
    if (bad_mem != 0) begin
      failures++;
      $display("FAIL final_ram: %0d locations differ from model, required 0", bad_mem);
    end
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      exp_mem[a]   = 4'h0;
      exp_valid[a] = 1'b0;
    end
    exp_adr = 0;
    test_reset();
    test_random_steps();
    test_single_write();
    test_write_disturb();
    test_simultaneous();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
